// File: rtl/mfp_ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter. M0 (CPU) and M1 (DMA/loader) each see a
// private slave port. Their transfers are serialised onto one shared master
// port. A request that loses arbitration is parked in a hold register and
// replayed later. Locked sequences and bursts are never split.
module mfp_ahb_lite_arb2 #(
  parameter logic FIXED_PRIO = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] m0_HADDR,
  input  logic [2:0]  m0_HBURST,
  input  logic        m0_HMASTLOCK,
  input  logic [3:0]  m0_HPROT,
  input  logic [2:0]  m0_HSIZE,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [31:0] m0_HWDATA,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,
  input  logic [31:0] m1_HADDR,
  input  logic [2:0]  m1_HBURST,
  input  logic        m1_HMASTLOCK,
  input  logic [3:0]  m1_HPROT,
  input  logic [2:0]  m1_HSIZE,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [31:0] m1_HWDATA,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,
  output logic [31:0] s_HADDR,
  output logic [2:0]  s_HBURST,
  output logic        s_HMASTLOCK,
  output logic [3:0]  s_HPROT,
  output logic [2:0]  s_HSIZE,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP
);

  // Address-phase bundle: {lock, burst, prot, size, write, trans, addr}
  // bit 45 lock, [33:32] trans (bit 33 = NONSEQ/SEQ, bit 32 = SEQ/BUSY)
  localparam int BW = 46;
  localparam logic [1:0] TRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {
    DOWN_NONE = 2'b00,
    DOWN_M0   = 2'b01,
    DOWN_M1   = 2'b10
  } down_t;

  logic [BW-1:0] live [2];
  logic [BW-1:0] hold_reg [2];
  logic [BW-1:0] src [2];
  logic [BW-1:0] own;
  logic [BW-1:0] bus;
  logic [1:0]    pend_reg;
  logic [1:0]    req;
  logic [1:0]    capture;
  logic [1:0]    hready_m;
  logic [1:0]    hresp_m;
  logic          aown_reg;
  logic          last_reg;
  logic          grant;
  logic          keep;
  logic          valid;
  down_t         down_reg;

  assign live[0] = {m0_HMASTLOCK, m0_HBURST, m0_HPROT, m0_HSIZE, m0_HWRITE, m0_HTRANS, m0_HADDR};
  assign live[1] = {m1_HMASTLOCK, m1_HBURST, m1_HPROT, m1_HSIZE, m1_HWRITE, m1_HTRANS, m1_HADDR};

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    localparam down_t MY_DOWN = (gi == 0) ? DOWN_M0 : DOWN_M1;
    localparam logic  MY_ID   = (gi == 0) ? 1'b0 : 1'b1;
    // A pending master is replayed from its hold register.
    assign src[gi]      = pend_reg[gi] ? hold_reg[gi] : live[gi];
    // Pending masters are stalled; the data-phase owner follows the slave.
    assign hready_m[gi] = pend_reg[gi] ? 1'b0 : ((down_reg == MY_DOWN) ? s_HREADY : 1'b1);
    assign hresp_m[gi]  = !pend_reg[gi] && (down_reg == MY_DOWN) && s_HRESP;
    assign req[gi]      = pend_reg[gi] | (live[gi][33] & hready_m[gi]);
    // A live request the slave does not accept this cycle must be parked.
    assign capture[gi]  = !pend_reg[gi] && live[gi][33] && hready_m[gi] &&
                          !((grant == MY_ID) && s_HREADY);
  end

  // Arbitration: keep owner through lock/burst, else round-robin or fixed.
  always_comb begin
    own  = src[aown_reg];
    keep = (own[45] || own[32]) &&
           !(s_HRESP && (down_reg == (aown_reg ? DOWN_M1 : DOWN_M0)) &&
             (own[33:32] == TRANS_IDLE));
    grant = aown_reg;
    if (s_HREADY && !keep) begin
      if (req == 2'b11)
        grant = FIXED_PRIO ? 1'b0 : ~last_reg;
      else if (req[0])
        grant = 1'b0;
      else if (req[1])
        grant = 1'b1;
    end
    bus   = src[grant];
    valid = req[grant] || ((grant == aown_reg) && keep) || (!s_HREADY && bus[33]);
  end

  assign {s_HMASTLOCK, s_HBURST, s_HPROT, s_HSIZE, s_HWRITE, s_HTRANS, s_HADDR} =
         valid ? bus : '0;

  // Write data follows the data-phase owner.
  always_comb begin
    s_HWDATA = 32'h0;
    case (down_reg)
      DOWN_M0: s_HWDATA = m0_HWDATA;
      DOWN_M1: s_HWDATA = m1_HWDATA;
      default: s_HWDATA = 32'h0;
    endcase
  end

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HREADY = hready_m[0];
  assign m1_HREADY = hready_m[1];
  assign m0_HRESP  = hresp_m[0];
  assign m1_HRESP  = hresp_m[1];

  // Hold registers and pending flags: set on a lost request, cleared on replay.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_reg    <= 2'b00;
      hold_reg[0] <= '0;
      hold_reg[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (capture[i]) begin
          pend_reg[i] <= 1'b1;
          hold_reg[i] <= live[i];
        end else if (pend_reg[i] && (grant == 1'(i)) && s_HREADY) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Ownership tracking; only advances when the slave accepts an address.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aown_reg <= 1'b0;
      last_reg <= 1'b1;
      down_reg <= DOWN_NONE;
    end else if (s_HREADY) begin
      aown_reg <= grant;
      down_reg <= s_HTRANS[1] ? (grant ? DOWN_M1 : DOWN_M0) : DOWN_NONE;
      if (s_HTRANS[1])
        last_reg <= grant;
    end
  end

endmodule
